unidad_procesadora_pipe: RTL

UNIDAD_PROCESADORA_PIPE -- requirements
Module: unidad_procesadora_pipe

---
 rtl/unidad_procesadora_pkg.sv | 60 ++++++
 rtl/unidad_procesadora_pipe_alu.sv | 49 ++++
 rtl/unidad_procesadora_pipe.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/unidad_procesadora_pkg.sv
// Shared constants for the pipelined processing unit:
// flag positions, ALU/shifter opcodes, control-word layout.
`timescale 1ns/1ps
package unidad_procesadora_pkg;

    localparam int FLAG_V = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam int F_W = 4;
    localparam int H_W = 3;

    localparam int CW_OFF_H = 0;
    localparam int CW_OFF_F = H_W;

    typedef enum logic [3:0] {
        F_PASS  = 4'b0000,
        F_INC   = 4'b0001,
        F_ADD   = 4'b0010,
        F_ADDC  = 4'b0011,
        F_SUBB  = 4'b0100,
        F_SUB   = 4'b0101,
        F_DEC   = 4'b0110,
        F_PASS1 = 4'b0111,
        F_AND   = 4'b1000,
        F_OR    = 4'b1010,
        F_XOR   = 4'b1100,
        F_NOT   = 4'b1110
    } f_op_e;

    typedef enum logic [2:0] {
        H_PASS  = 3'b000,
        H_SHL   = 3'b001,
        H_LSR   = 3'b010,
        H_ZERO  = 3'b011,
        H_ASR   = 3'b100,
        H_ROL   = 3'b101,
        H_ROR   = 3'b110,
        H_PASS7 = 3'b111
    } h_op_e;

    // Control word is {A, B, D, F, H}, most significant field first.
    function automatic int cw_width(input int aw);
        return 3 * aw + F_W + H_W;
    endfunction

    function automatic int cw_off_d(input int aw);
        return (aw > 0) ? F_W + H_W : F_W + H_W;
    endfunction

    function automatic int cw_off_b(input int aw);
        return aw + F_W + H_W;
    endfunction

    function automatic int cw_off_a(input int aw);
        return 2 * aw + F_W + H_W;
    endfunction

endpackage

// File: rtl/unidad_procesadora_pipe_alu.sv
// N-bit ALU: add with selectable second operand and carry-in,
// or bitwise logic; produces {V,S,Z,C}.
`timescale 1ns/1ps
module alu_n
    import unidad_procesadora_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   f,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    logic [N-1:0] y;
    logic [N:0]   sum;

    always_comb begin
        y = '0;
        unique case (f[2:1])
            2'b00: y = '0;
            2'b01: y = b;
            2'b10: y = ~b;
            2'b11: y = '1;
        endcase

        sum = {1'b0, a} + {1'b0, y} + {{N{1'b0}}, f[0]};

        result = '0;
        flags  = '0;
        if (!f[3]) begin
            result         = sum[N-1:0];
            flags[FLAG_C]  = sum[N];
            flags[FLAG_V]  = (a[N-1] == y[N-1]) &&
                             (sum[N-1] != a[N-1]);
        end else begin
            unique case (f[2:1])
                2'b00: result = a & b;
                2'b01: result = a | b;
                2'b10: result = a ^ b;
                2'b11: result = ~a;
            endcase
        end
        flags[FLAG_S] = result[N-1];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/unidad_procesadora_pipe.sv
// Two-stage processing unit: operand read + ALU into S1,
// shifter into S2, register writeback on output transfer.
`timescale 1ns/1ps
module unidad_procesadora_pipe
    import unidad_procesadora_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREG = 8,
    localparam int AW  = $clog2(NREG),
    localparam int CW  = cw_width(AW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] ctr_word,
    input  logic [N-1:0]  data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  data_out,
    output logic [3:0]    flags
);

    localparam int OFF_A = cw_off_a(AW);
    localparam int OFF_B = cw_off_b(AW);
    localparam int OFF_D = cw_off_d(AW);

    logic [AW-1:0] fa;
    logic [AW-1:0] fb;
    logic [AW-1:0] fd;
    logic [3:0]    ff;
    logic [2:0]    fh;

    assign fa = ctr_word[OFF_A +: AW];
    assign fb = ctr_word[OFF_B +: AW];
    assign fd = ctr_word[OFF_D +: AW];
    assign ff = ctr_word[CW_OFF_F +: F_W];
    assign fh = ctr_word[CW_OFF_H +: H_W];

    logic [N-1:0] rf [NREG];

    logic          s1_valid;
    logic [N-1:0]  s1_res;
    logic [3:0]    s1_flags;
    logic [AW-1:0] s1_d;
    logic [2:0]    s1_h;

    logic          s2_valid;
    logic [N-1:0]  s2_data;
    logic [3:0]    s2_flags;
    logic [AW-1:0] s2_d;

    logic [N-1:0]  s1_sh;
    logic [N-1:0]  bus_a;
    logic [N-1:0]  bus_b;
    logic [N-1:0]  alu_res;
    logic [3:0]    alu_flags;

    logic xfer;
    logic s2_free;
    logic s1_adv;

    function automatic logic [N-1:0] shift(
        input logic [N-1:0] x,
        input logic [2:0]   h
    );
        logic [N-1:0] r;
        r = x;
        unique case (h_op_e'(h))
            H_PASS:  r = x;
            H_SHL:   r = {x[N-2:0], 1'b0};
            H_LSR:   r = {1'b0, x[N-1:1]};
            H_ZERO:  r = '0;
            H_ASR:   r = {x[N-1], x[N-1:1]};
            H_ROL:   r = {x[N-2:0], x[N-1]};
            H_ROR:   r = {x[0], x[N-1:1]};
            H_PASS7: r = x;
        endcase
        return r;
    endfunction

    assign s1_sh = shift(s1_res, s1_h);

    assign xfer     = s2_valid && out_ready;
    assign s2_free  = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !reset && (!s1_valid || s1_adv);

    assign out_valid = s2_valid;
    assign data_out  = s2_data;
    assign flags     = s2_flags;

    // Youngest in-flight producer wins; S2 also covers same-edge writeback.
    always_comb begin
        bus_a = rf[fa];
        if (fa == '0)
            bus_a = data_in;
        else if (s1_valid && s1_d == fa)
            bus_a = s1_sh;
        else if (s2_valid && s2_d == fa)
            bus_a = s2_data;

        bus_b = rf[fb];
        if (fb == '0)
            bus_b = data_in;
        else if (s1_valid && s1_d == fb)
            bus_b = s1_sh;
        else if (s2_valid && s2_d == fb)
            bus_b = s2_data;
    end

    alu_n #(.N(N)) u_alu (
        .a      (bus_a),
        .b      (bus_b),
        .f      (ff),
        .result (alu_res),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_flags <= '0;
            s1_d     <= '0;
            s1_h     <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_flags <= '0;
            s2_d     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_res   <= alu_res;
                    s1_flags <= alu_flags;
                    s1_d     <= fd;
                    s1_h     <= fh;
                end
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data  <= s1_sh;
                    s2_flags <= s1_flags;
                    s2_d     <= s1_d;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (xfer && s2_d != '0) begin
            rf[s2_d] <= s2_data;
        end
    end

endmodule
